// File: rtl/dual_port_mem_arbiter_pkg.sv
// Shared types for the dual-port memory arbiter: size defaults, per-port read tag, index helpers.
// Pure declarations, no timing or backpressure of its own.
package mem_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 3;
    localparam int DW_DEF   = 15;
    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = 3;

    typedef logic [IDX_W-1:0] idx_t;

    // One per memory port: which requester owns the data coming back next cycle.
    typedef struct packed {
        logic valid;
        logic rd;
        idx_t idx;
    } port_tag_t;

    localparam port_tag_t TAG_IDLE = '0;

    function automatic idx_t wrap_inc(input idx_t i, input int n);
        if (int'(i) + 1 >= n) begin
            return '0;
        end
        return idx_t'(int'(i) + 1);
    endfunction

endpackage

// File: rtl/dual_port_mem_arbiter_if.sv
// Requester-side handshake plus memory A/B port pins of the arbiter, grouped in one bundle.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dual_port_mem_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 15
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [NREQ*DW-1:0] rdata;

    logic               enA;
    logic               enB;
    logic [AW-1:0]      addrA;
    logic [AW-1:0]      addrB;
    logic [DW-1:0]      dataA;
    logic [DW-1:0]      dataB;
    logic [DW-1:0]      qA;
    logic [DW-1:0]      qB;

    modport master (
        output req, we, addr, wdata, qA, qB,
        input  gnt, rvalid, rdata, enA, enB, addrA, addrB, dataA, dataB
    );

    modport slave (
        input  req, we, addr, wdata, qA, qB,
        output gnt, rvalid, rdata, enA, enB, addrA, addrB, dataA, dataB
    );

endinterface

// File: rtl/dual_port_mem_arbiter_rr_picker.sv
// Round-robin picker: first set bit of mask at or after start, wrapping modulo N.
// Purely combinational, no backpressure.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] mask,
    input  idx_t         start,
    output logic         found,
    output idx_t         idx
);

    int best_off;
    int off;

    // Smallest wrap distance from start wins; ties cannot occur.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        best_off = N;
        off      = 0;
        for (int j = 0; j < N; j++) begin
            off = (j + N - int'(start)) % N;
            if (mask[j] && (off < best_off)) begin
                best_off = off;
                found    = 1'b1;
                idx      = idx_t'(j);
            end
        end
    end

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// Shares a dual-port memory between NREQ requesters: up to two grants per cycle, same cycle as req.
// Read data returns on rvalid one cycle after grant; ungranted requesters simply hold req.
module dual_port_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    dual_port_mem_arbiter_if.slave bus
);

    logic [AW-1:0] req_addr  [NREQ];
    logic [DW-1:0] req_wdata [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_addr[g]  = bus.addr[g*AW +: AW];
        assign req_wdata[g] = bus.wdata[g*DW +: DW];
    end

    idx_t          ptr;
    port_tag_t     tag_a;
    port_tag_t     tag_b;

    logic          found_a;
    logic          found_b;
    idx_t          idx_a;
    idx_t          idx_b;
    idx_t          start_b;
    logic [NREQ-1:0] mask_b;
    logic          grant_a;
    logic          grant_b;

    logic [AW-1:0] sel_addr_a;
    logic [AW-1:0] sel_addr_b;
    logic [DW-1:0] sel_wdata_a;
    logic [DW-1:0] sel_wdata_b;
    logic          sel_we_a;
    logic          sel_we_b;

    rr_picker #(.N(NREQ)) u_pick_a (
        .mask  (bus.req),
        .start (ptr),
        .found (found_a),
        .idx   (idx_a)
    );

    always_comb begin
        sel_addr_a  = '0;
        sel_wdata_a = '0;
        sel_we_a    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx_a == idx_t'(i)) begin
                sel_addr_a  = req_addr[i];
                sel_wdata_a = req_wdata[i];
                sel_we_a    = bus.we[i];
            end
        end
    end

    // Port B may not touch port A's address if either side writes; equal-address reads are fine.
    always_comb begin
        mask_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask_b[i] = bus.req[i] && found_a && (idx_a != idx_t'(i)) &&
                        !((req_addr[i] == sel_addr_a) && (bus.we[i] || sel_we_a));
        end
    end

    assign start_b = wrap_inc(idx_a, NREQ);

    rr_picker #(.N(NREQ)) u_pick_b (
        .mask  (mask_b),
        .start (start_b),
        .found (found_b),
        .idx   (idx_b)
    );

    always_comb begin
        sel_addr_b  = '0;
        sel_wdata_b = '0;
        sel_we_b    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx_b == idx_t'(i)) begin
                sel_addr_b  = req_addr[i];
                sel_wdata_b = req_wdata[i];
                sel_we_b    = bus.we[i];
            end
        end
    end

    // Reset forces every grant and memory strobe low even with requests pending.
    assign grant_a = rst_n && found_a;
    assign grant_b = rst_n && found_b;

    always_comb begin
        bus.gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.gnt[i] = (grant_a && (idx_a == idx_t'(i))) ||
                         (grant_b && (idx_b == idx_t'(i)));
        end
    end

    always_comb begin
        bus.enA   = 1'b0;
        bus.addrA = '0;
        bus.dataA = '0;
        bus.enB   = 1'b0;
        bus.addrB = '0;
        bus.dataB = '0;
        if (grant_a) begin
            bus.enA   = sel_we_a;
            bus.addrA = sel_addr_a;
            bus.dataA = sel_we_a ? sel_wdata_a : '0;
        end
        if (grant_b) begin
            bus.enB   = sel_we_b;
            bus.addrB = sel_addr_b;
            bus.dataB = sel_we_b ? sel_wdata_b : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            tag_a <= TAG_IDLE;
            tag_b <= TAG_IDLE;
        end else begin
            if (found_b) begin
                ptr <= wrap_inc(idx_b, NREQ);
            end else if (found_a) begin
                ptr <= wrap_inc(idx_a, NREQ);
            end
            tag_a <= '{valid: found_a, rd: !sel_we_a, idx: idx_a};
            tag_b <= '{valid: found_b, rd: !sel_we_b, idx: idx_b};
        end
    end

    // Memory q is already registered, so routing it by the stored tag lands exactly one cycle after grant.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag_a.valid && tag_a.rd && (tag_a.idx == idx_t'(i))) begin
                bus.rvalid[i]         = 1'b1;
                bus.rdata[i*DW +: DW] = bus.qA;
            end
            if (tag_b.valid && tag_b.rd && (tag_b.idx == idx_t'(i))) begin
                bus.rvalid[i]         = 1'b1;
                bus.rdata[i*DW +: DW] = bus.qB;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Directed and random stimulus for dual_port_mem_arbiter, checked against a queue-based reference model.
module tb_dual_port_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dual_port_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

    dual_port_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Physical memory attached to the A/B pins: registered read, write at the edge.
    logic [DW-1:0] phys_mem [8];
    always @(posedge clk) begin
        if (bif.enA) phys_mem[bif.addrA] <= bif.dataA;
        if (bif.enB) phys_mem[bif.addrB] <= bif.dataB;
        bif.qA <= phys_mem[bif.addrA];
        bif.qB <= phys_mem[bif.addrB];
    end

    logic                t_rst;
    logic [NREQ-1:0]     t_req;
    logic [NREQ-1:0]     t_we;
    logic [AW-1:0]       t_addr  [NREQ];
    logic [DW-1:0]       t_wdata [NREQ];

    int                  m_ptr;
    logic [DW-1:0]       ref_mem [8];
    logic [NREQ-1:0]     exp_rvalid;
    logic [NREQ*DW-1:0]  exp_rdata;
    int                  last_a;
    int                  last_b;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        rst_n   = t_rst;
        bif.req = t_req;
        bif.we  = t_we;
        for (int i = 0; i < NREQ; i++) begin
            bif.addr[i*AW +: AW]  = t_addr[i];
            bif.wdata[i*DW +: DW] = t_wdata[i];
        end
    endtask

    task automatic model_check();
        int a;
        int b;
        int j;
        int order[$];
        logic [NREQ-1:0]    eg;
        logic               e_en_a, e_en_b;
        logic [AW-1:0]      e_ad_a, e_ad_b;
        logic [DW-1:0]      e_dt_a, e_dt_b;
        logic [NREQ-1:0]    nxt_rv;
        logic [NREQ*DW-1:0] nxt_rd;
        a = -1; b = -1; eg = '0;
        e_en_a = 1'b0; e_en_b = 1'b0; e_ad_a = '0; e_ad_b = '0; e_dt_a = '0; e_dt_b = '0;
        if (!t_rst) begin
            exp_rvalid = '0;
            exp_rdata  = '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (t_req[j]) order.push_back(j);
            end
            if (order.size() > 0) a = order[0];
            for (int n = 1; n < order.size(); n++) begin
                if (b < 0 && !(t_addr[order[n]] == t_addr[a] && (t_we[order[n]] || t_we[a])))
                    b = order[n];
            end
        end
        if (a >= 0) begin
            eg[a] = 1'b1; e_en_a = t_we[a]; e_ad_a = t_addr[a];
            e_dt_a = t_we[a] ? t_wdata[a] : '0;
        end
        if (b >= 0) begin
            eg[b] = 1'b1; e_en_b = t_we[b]; e_ad_b = t_addr[b];
            e_dt_b = t_we[b] ? t_wdata[b] : '0;
        end
        chk("gnt",    64'(bif.gnt),    64'(eg));
        chk("enA",    64'(bif.enA),    64'(e_en_a));
        chk("addrA",  64'(bif.addrA),  64'(e_ad_a));
        chk("dataA",  64'(bif.dataA),  64'(e_dt_a));
        chk("enB",    64'(bif.enB),    64'(e_en_b));
        chk("addrB",  64'(bif.addrB),  64'(e_ad_b));
        chk("dataB",  64'(bif.dataB),  64'(e_dt_b));
        chk("rvalid", 64'(bif.rvalid), 64'(exp_rvalid));
        chk("rdata",  64'(bif.rdata),  64'(exp_rdata));
        nxt_rv = '0;
        nxt_rd = '0;
        if (a >= 0 && !t_we[a]) begin
            nxt_rv[a] = 1'b1;
            nxt_rd[a*DW +: DW] = ref_mem[t_addr[a]];
        end
        if (b >= 0 && !t_we[b]) begin
            nxt_rv[b] = 1'b1;
            nxt_rd[b*DW +: DW] = ref_mem[t_addr[b]];
        end
        if (a >= 0 && t_we[a]) ref_mem[t_addr[a]] = t_wdata[a];
        if (b >= 0 && t_we[b]) ref_mem[t_addr[b]] = t_wdata[b];
        if (!t_rst)      m_ptr = 0;
        else if (b >= 0) m_ptr = (b + 1) % NREQ;
        else if (a >= 0) m_ptr = (a + 1) % NREQ;
        exp_rvalid = t_rst ? nxt_rv : '0;
        exp_rdata  = t_rst ? nxt_rd : '0;
        last_a = a;
        last_b = b;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        model_check();
    endtask

    task automatic set_req(input int i, input logic w, input int ad, input logic [DW-1:0] d);
        t_req[i]   = 1'b1;
        t_we[i]    = w;
        t_addr[i]  = AW'(ad);
        t_wdata[i] = d;
    endtask

    task automatic clear_all();
        t_req = '0;
        t_we  = '0;
    endtask

    initial begin
        t_rst = 1'b0;
        clear_all();
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            phys_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        m_ptr = 0; exp_rvalid = '0; exp_rdata = '0; last_a = -1; last_b = -1;
        drive();

        // Reset holds everything quiet despite all requests asserted.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, '0);
        step();
        chk("rst_gnt",    64'(bif.gnt),    64'(0));
        chk("rst_en",     64'({bif.enA, bif.enB}), 64'(0));
        chk("rst_rvalid", 64'(bif.rvalid), 64'(0));
        step();
        t_rst = 1'b1;
        step();
        chk("rel_gnt",   64'(bif.gnt),   64'(4'b0011));
        chk("rel_addrB", 64'(bif.addrB), 64'(1));
        clear_all();
        step();

        // Write then read back on requester 2.
        set_req(2, 1'b1, 5, 15'h1ABC);
        step();
        chk("wr_gnt", 64'(bif.gnt), 64'(4'b0100));
        chk("wr_enA", 64'(bif.enA), 64'(1));
        set_req(2, 1'b0, 5, '0);
        step();
        chk("rd_gnt", 64'(bif.gnt), 64'(4'b0100));
        clear_all();
        step();
        chk("rd_rvalid", 64'(bif.rvalid), 64'(4'b0100));
        chk("rd_rdata",  64'(bif.rdata[2*DW +: DW]), 64'(15'h1ABC));

        // Bring ptr back to 0, then all four read continuously.
        set_req(3, 1'b0, 6, '0);
        step();
        clear_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, '0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fair_gnt", 64'(bif.gnt), (c % 2 == 0) ? 64'(4'b0011) : 64'(4'b1100));
        end
        clear_all();
        step();

        // Write/read conflict on addr 3 with ptr at 0.
        set_req(0, 1'b1, 3, 15'h05A5);
        set_req(1, 1'b0, 3, '0);
        set_req(2, 1'b0, 4, '0);
        step();
        chk("conf_gnt", 64'(bif.gnt), 64'(4'b0101));
        t_req[0] = 1'b0;
        t_req[2] = 1'b0;
        step();
        chk("conf_gnt2", 64'(bif.gnt), 64'(4'b0010));
        clear_all();
        step();
        chk("conf_rdata", 64'(bif.rdata[1*DW +: DW]), 64'(15'h05A5));

        // Two reads of the same address share the cycle.
        set_req(0, 1'b1, 7, 15'h0042);
        step();
        clear_all();
        set_req(1, 1'b0, 7, '0);
        set_req(3, 1'b0, 7, '0);
        step();
        chk("same_gnt", 64'(bif.gnt), 64'(4'b1010));
        clear_all();
        step();
        chk("same_rv",  64'(bif.rvalid), 64'(4'b1010));
        chk("same_rd1", 64'(bif.rdata[1*DW +: DW]), 64'(15'h0042));
        chk("same_rd3", 64'(bif.rdata[3*DW +: DW]), 64'(15'h0042));

        // Reset right after a read grant drops the return and rewinds ptr.
        set_req(0, 1'b0, 5, '0);
        step();
        clear_all();
        t_rst = 1'b0;
        step();
        chk("mid_rvalid", 64'(bif.rvalid), 64'(0));
        t_rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, '0);
        step();
        chk("mid_ptr_gnt", 64'(bif.gnt), 64'(4'b0011));
        clear_all();
        step();

        // Random traffic: requests held until the model grants them.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!t_req[i] && ($urandom_range(0, 2) != 0))
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), DW'($urandom));
            end
            step();
            if (last_a >= 0) t_req[last_a] = 1'b0;
            if (last_b >= 0) t_req[last_b] = 1'b0;
        end
        clear_all();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_arbiter.md
# dual_port_mem_arbiter

Round-robin arbiter that shares the 8-entry × 15-bit dual-port memory between `NREQ` requesters. Each cycle it grants up to two requests, one per memory port, and blocks same-address conflicts. It returns read data to the owning requester one cycle after the grant. It sits between the Lab7 requester logic and the memory's A/B port pins.

## Interface
- `NREQ`, 4: number of requesters (2–8).
- `AW`, 3: address width.
- `DW`, 15: data width.

Ports:
- `clk` input 1: single clock, all state on posedge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req` input NREQ: request valid, one bit per requester.
- `we` input NREQ: 1 = write, 0 = read.
- `addr` input NREQ*AW: packed addresses, requester i at `[i*AW +: AW]`.
- `wdata` input NREQ*DW: packed write data.
- `gnt` output NREQ: one-cycle grant pulse, combinational.
- `rvalid` output NREQ: read data valid, registered.
- `rdata` output NREQ*DW: packed read data, valid when `rvalid[i]`.
- `enA`, `enB` output 1: memory write enables.
- `addrA`, `addrB` output AW: memory addresses.
- `dataA`, `dataB` output DW: memory write data.
- `qA`, `qB` input DW: memory registered read data, 1-cycle latency.

## Operation
- **Handshake:**
  - Requester asserts `req[i]` with `we/addr/wdata` and holds them stable until the cycle `gnt[i]`=1.
  - The transfer happens in that cycle.
  - Next cycle the requester may drop `req` or present a new request.
  - `gnt` is never asserted without `req`.
- **Pick 1:**
  - First requesting index scanning upward from `ptr`, wrapping modulo NREQ.
  - Drives port A.
- **Pick 2:**
  - Next requesting index after pick 1, same wrap order.
  - Excludes any requester whose address equals pick 1's address while either request is a write.
  - Drives port B.
  - An excluded requester is not granted this cycle.
- **Both ports read the same address:** allowed; both granted.
- **Port drive:**
  - Granted port gets `addrX` = requester addr and `enX` = `we`.
  - `dataX` = wdata when writing, 0 otherwise.
  - Idle port drives `enX`=0, `addrX`=0, `dataX`=0.
- **Pointer update:**
  - `ptr` <= (last granted index + 1) mod NREQ.
  - No grant: `ptr` unchanged.
  - Guarantees each persistent requester a grant within NREQ cycles.
- **Read return:**
  - `tagA`/`tagB` registers record the granted requester and a read flag.
  - Cycle t+1: `rvalid[tag]`=1 and `rdata[tag]` = `qA`/`qB`.
  - All other `rdata` slices are 0.
  - Writes produce no `rvalid`.
- **Read to an address written on the other port in the same cycle:** cannot occur, because of the conflict exclusion.

## Timing
- **Reset (`rst_n`=0):**
  - `ptr`=0, tags invalid.
  - `rvalid`=0, `rdata`=0.
  - `gnt`=0, `enA`=`enB`=0.
  - All memory outputs are 0, forced regardless of `req`.
- **Latency:**
  - Grant is same cycle as the request, 0 wait when uncontended.
  - Read data arrives 1 cycle after grant.
  - Write is committed at the grant-cycle edge.
- **Throughput:** 2 transfers/cycle maximum.
- **Reset mid-operation:** pending `rvalid` of the in-flight read is dropped; requesters re-request.
- **Single requester:** always port A, port B idle.

## Structure
- **Package `mem_arb_pkg`:** `AW`/`DW` defaults and a `port_tag_t` struct {valid, rd, idx}.
- **Sub-module `rr_picker`:**
  - Inputs: request mask, start pointer.
  - Outputs: found flag, index.
  - Instantiated twice; the second instance gets the mask with pick 1 and the conflicting requesters cleared, starting at pick 1 + 1.

## Test plan
- **Reset:** hold `rst_n`=0 with all `req`=1 → `gnt`=0, `enA`=`enB`=0, `rvalid`=0. Release → first cycle grants req0 (A) and req1 (B).
- **Write then read:** req2 writes 0x1ABC to addr 5; next cycle req2 reads addr 5 → `gnt[2]` each cycle, `rvalid[2]`=1 one cycle later, `rdata[2]`=0x1ABC.
- **Fairness:** all 4 requesters read distinct addresses continuously → grant pairs {0,1},{2,3},{0,1} repeating; no requester waits more than 2 cycles.
- **Write conflict:** req0 writes addr 3, req1 reads addr 3, req2 reads addr 4, `ptr`=0 → grants req0 (A) and req2 (B); req1 granted the next cycle and reads the new value.
- **Same-address reads:** req1 and req3 both read addr 7 (value 0x0042) → both granted the same cycle; `rdata[1]`=`rdata[3]`=0x0042 the next cycle.
- **Reset mid-read:** assert `rst_n`=0 one cycle after a read grant → `rvalid` stays 0 and `ptr` returns to 0.
